data_ram: RTL and testbench

Word-organised data RAM that sits on the RAM side of `memoryController`. It accepts byte-laned store requests and word load requests from the controller. Stores commit in one cycle under the 4-bit `byteSelect` mask. Loads return the full 32-bit word after a fixed, parameterised latency with a valid/ready handshake. The controller performs all lane shifting and sign extension; this block neither shifts nor sign-extends.

---
 rtl/data_ram.sv | 153 +++++++++++++++
 tb/tb_data_ram.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_ram.sv
// data_ram: word-organised data RAM behind the memory controller.
// Byte-laned single-cycle stores, full-word loads returned after
// READ_LATENCY cycles with a readValid pulse. No shifting or sign extension.
// Optional feature macro: RAM_RANGE_CHECK_EN (out-of-range detection and the
// accessFault pulse). Without it, addresses alias modulo DEPTH.
module data_ram #(
    parameter int DATA_WIDTH   = 32,
    parameter int DEPTH        = 1024,
    parameter int READ_LATENCY = 2,
    parameter int ADDR_BITS    = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] addressIn,
    input  logic [DATA_WIDTH-1:0] dataWriteIn,
    input  logic [3:0]            byteSelect,
    input  logic                  storeIn,
    input  logic                  loadIn,
    output logic [DATA_WIDTH-1:0] dataReadOut,
    output logic                  readValid,
    output logic                  ready,
    output logic                  accessFault
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam bit                LAT1    = (READ_LATENCY == 1);
    localparam logic [1:0]        CNT_INI = 2'(READ_LATENCY - 1);
    localparam logic [ADDR_BITS:0] DEPTH_W = (ADDR_BITS+1)'(DEPTH);

    // captured load request
    typedef struct packed {
        logic [ADDR_BITS-1:0] idx;
        logic                 oor;
    } ld_req_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [1:0]            state;
    logic [1:0]            cnt;
    ld_req_t               ld_q;
    logic [ADDR_BITS:0]    raw_ext;
    logic [ADDR_BITS-1:0]  req_idx;
    logic                  req_oor;
    logic                  st_acc;
    logic                  ld_acc;
    logic                  wr_en;
    logic                  go_resp;
    logic                  resp_oor;
    logic [DATA_WIDTH-1:0] fwd_word;
    logic [DATA_WIDTH-1:0] resp_word;
    logic                  unused_addr_bits;

    // ready depends on state only, never on the request inputs
    assign ready  = (state != S_WAIT);
    assign st_acc = ready & storeIn;
    assign ld_acc = ready & loadIn;
    assign wr_en  = st_acc & ~req_oor;

    assign unused_addr_bits = ^addressIn[1:0];

    // word index, folded into 0..DEPTH-1 for non-power-of-two depths
    always_comb begin
        raw_ext = {1'b0, addressIn[ADDR_BITS+1:2]};
        req_idx = raw_ext[ADDR_BITS-1:0];
        if (raw_ext >= DEPTH_W)
            req_idx = ADDR_BITS'(raw_ext - DEPTH_W);
    end

`ifdef RAM_RANGE_CHECK_EN
    localparam logic [DATA_WIDTH:0] LIMIT = (DATA_WIDTH+1)'(4 * DEPTH);
    // full byte address compared against the array size
    always_comb req_oor = ({1'b0, addressIn} >= LIMIT);
`else
    // aliasing mode: nothing is ever out of range
    always_comb req_oor = 1'b0;
`endif

    // with single-cycle latency the read happens on the write edge, so merge
    // the store bytes into the returned word
    always_comb begin
        fwd_word = mem[req_idx];
        for (int i = 0; i < 4; i++)
            if (wr_en && byteSelect[i])
                fwd_word[8*i +: 8] = dataWriteIn[8*i +: 8];
    end

    // word delivered when the FSM enters RESP
    always_comb begin
        if (LAT1) begin
            go_resp   = ld_acc;
            resp_oor  = req_oor;
            resp_word = req_oor ? '0 : fwd_word;
        end else begin
            go_resp   = (state == S_WAIT) && (cnt == 2'd1);
            resp_oor  = ld_q.oor;
            resp_word = ld_q.oor ? '0 : mem[ld_q.idx];
        end
    end

    // byte-laned write port; storage is not reset
    always_ff @(posedge clk) begin
        if (wr_en)
            for (int i = 0; i < 4; i++)
                if (byteSelect[i])
                    mem[req_idx][8*i +: 8] <= dataWriteIn[8*i +: 8];
    end

    // load FSM, latency counter and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            cnt         <= 2'd0;
            ld_q        <= '0;
            readValid   <= 1'b0;
            dataReadOut <= '0;
            accessFault <= 1'b0;
        end else begin
            readValid   <= go_resp;
            accessFault <= (st_acc & req_oor) | (go_resp & resp_oor);
            if (go_resp)
                dataReadOut <= resp_word;
            case (state)
                S_IDLE, S_RESP: begin
                    if (ld_acc) begin
                        ld_q.idx <= req_idx;
                        ld_q.oor <= req_oor;
                        if (LAT1) begin
                            state <= S_RESP;
                        end else begin
                            state <= S_WAIT;
                            cnt   <= CNT_INI;
                        end
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (cnt == 2'd1) begin
                        state <= S_RESP;
                        cnt   <= 2'd0;
                    end else begin
                        cnt <= cnt - 2'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_ram.sv
// tb_data_ram: table vectors, hand sequences and a randomized run against a
// byte-addressed reference memory.
module tb_data_ram;

    localparam int DEPTH = 1024;
    localparam int LAT   = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] addressIn;
    logic [31:0] dataWriteIn;
    logic [3:0]  byteSelect;
    logic        storeIn;
    logic        loadIn;
    logic [31:0] dataReadOut;
    logic        readValid;
    logic        ready;
    logic        accessFault;

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0] mbytes [4*DEPTH];

    data_ram #(.DATA_WIDTH(32), .DEPTH(DEPTH), .READ_LATENCY(LAT)) dut (
        .clk(clk), .reset_n(reset_n), .addressIn(addressIn),
        .dataWriteIn(dataWriteIn), .byteSelect(byteSelect),
        .storeIn(storeIn), .loadIn(loadIn), .dataReadOut(dataReadOut),
        .readValid(readValid), .ready(ready), .accessFault(accessFault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] st_addr;
        logic [31:0] init;
        logic [31:0] data;
        logic [3:0]  be;
        logic [31:0] ld_addr;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic bit model_oor(input logic [31:0] a);
`ifdef RAM_RANGE_CHECK_EN
        return a >= 32'(4*DEPTH);
`else
        return (a == 32'hFFFF_FFFF) && 1'b0;
`endif
    endfunction

    function automatic int model_base(input logic [31:0] a);
        return int'((a / 4) % DEPTH) * 4;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        int b;
        if (model_oor(a)) return 32'h0;
        b = model_base(a);
        return {mbytes[b+3], mbytes[b+2], mbytes[b+1], mbytes[b]};
    endfunction

    task automatic model_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        int b;
        if (model_oor(a)) return;
        b = model_base(a);
        for (int i = 0; i < 4; i++)
            if (be[i]) mbytes[b+i] = d[8*i +: 8];
    endtask

    // single store; caller is at a negedge with ready=1, returns at a negedge
    task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        addressIn = a; dataWriteIn = d; byteSelect = be; storeIn = 1'b1;
        model_store(a, d, be);
        @(posedge clk); #1;
        storeIn = 1'b0;
        @(negedge clk);
    endtask

    // waits for readValid, counting negedges and cycles with ready=0
    task automatic wait_resp(output int lat, output int lowcnt);
        lat = 0; lowcnt = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (readValid) begin lat = c; break; end
            if (!ready) lowcnt++;
        end
    endtask

    // load (optionally with a simultaneous store); checks latency, data, fault, ready
    task automatic do_load(input string name, input logic [31:0] a, input logic st,
                           input logic [31:0] sd, input logic [3:0] sbe,
                           input logic [31:0] exp, input logic exp_fault);
        int lat, lowcnt;
        addressIn = a; loadIn = 1'b1;
        storeIn = st; dataWriteIn = sd; byteSelect = sbe;
        @(posedge clk); #1;
        loadIn = 1'b0; storeIn = 1'b0;
        wait_resp(lat, lowcnt);
        chk({name, "_latency"}, lat, LAT);
        chk({name, "_data"}, dataReadOut, exp);
        chk({name, "_fault"}, {31'd0, accessFault}, {31'd0, exp_fault});
        chk({name, "_ready_low"}, lowcnt, LAT-1);
    endtask

    initial begin
        int          lat, lowcnt;
        logic        seen;
        logic [31:0] a, d, e;
        logic [3:0]  be;
        int          op;

        vecs[0] = '{32'h10, 32'h0,        32'hDEADBEEF, 4'hF,    32'h10, 32'hDEADBEEF};
        vecs[1] = '{32'h20, 32'h11223344, 32'h0000AA00, 4'b0010, 32'h20, 32'h1122AA44};
        vecs[2] = '{32'h24, 32'hAABBCCDD, 32'h11000000, 4'b1000, 32'h24, 32'h11BBCCDD};
        vecs[3] = '{32'h28, 32'h01234567, 32'hFFFFFFFF, 4'b0000, 32'h28, 32'h01234567};
        vecs[4] = '{32'h2C, 32'h01234567, 32'hF0F0F0F0, 4'b0101, 32'h2C, 32'h01F045F0};
        vecs[5] = '{32'h37, 32'h0,        32'hCAFEF00D, 4'hF,    32'h34, 32'hCAFEF00D};

        for (int i = 0; i < 4*DEPTH; i++) mbytes[i] = 8'h0;
        addressIn = '0; dataWriteIn = '0; byteSelect = '0;
        storeIn = 1'b0; loadIn = 1'b0; reset_n = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_ready", {31'd0, ready}, 32'd1);
        chk("rst_readValid", {31'd0, readValid}, 32'd0);
        chk("rst_dataReadOut", dataReadOut, 32'd0);
        chk("rst_accessFault", {31'd0, accessFault}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // clear all words so the model matches known contents
        for (int w = 0; w < DEPTH; w++) do_store(32'(w*4), 32'h0, 4'hF);

        // partial-write table
        for (int i = 0; i < 6; i++) begin
            do_store(vecs[i].st_addr, vecs[i].init, 4'hF);
            do_store(vecs[i].st_addr, vecs[i].data, vecs[i].be);
            do_load("tbl", vecs[i].ld_addr, 1'b0, 32'h0, 4'h0, vecs[i].exp, 1'b0);
        end

        // simultaneous store and load
        model_store(32'h30, 32'h55667788, 4'hF);
        do_load("simul", 32'h30, 1'b1, 32'h55667788, 4'hF, 32'h55667788, 1'b0);

        // store while ready=0 is ignored
        do_store(32'h40, 32'hA5A55A5A, 4'hF);
        addressIn = 32'h40; loadIn = 1'b1;
        @(posedge clk); #1;
        loadIn = 1'b0;
        @(negedge clk);
        chk("blk_ready", {31'd0, ready}, 32'd0);
        storeIn = 1'b1; dataWriteIn = 32'h0BADF00D; byteSelect = 4'hF;
        @(posedge clk); #1;
        storeIn = 1'b0;
        wait_resp(lat, lowcnt);
        chk("blk_first_lat", lat, 1);
        chk("blk_first_data", dataReadOut, 32'hA5A55A5A);
        do_load("blk_reread", 32'h40, 1'b0, 32'h0, 4'h0, 32'hA5A55A5A, 1'b0);

        // reset aborts an outstanding load
        addressIn = 32'h10; loadIn = 1'b1;
        @(posedge clk); #1;
        loadIn = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("abort_ready", {31'd0, ready}, 32'd1);
        chk("abort_readValid", {31'd0, readValid}, 32'd0);
        chk("abort_dataReadOut", dataReadOut, 32'd0);
        seen = 1'b0;
        repeat (3) begin @(negedge clk); seen |= readValid; end
        reset_n = 1'b1;
        repeat (4) begin @(negedge clk); seen |= readValid; end
        chk("abort_no_pulse", {31'd0, seen}, 32'd0);
        do_load("abort_after", 32'h10, 1'b0, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);

        // range behaviour at 4*DEPTH
        e = model_read(32'h0);
        do_store(32'h1000, 32'h12345678, 4'hF);
`ifdef RAM_RANGE_CHECK_EN
        chk("oor_store_fault", {31'd0, accessFault}, 32'd1);
        @(negedge clk);
        chk("oor_fault_pulse", {31'd0, accessFault}, 32'd0);
        do_load("oor_word0", 32'h0, 1'b0, 32'h0, 4'h0, e, 1'b0);
        do_load("oor_load", 32'h1000, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1);
`else
        chk("alias_store_fault", {31'd0, accessFault}, 32'd0);
        do_load("alias_word0", 32'h0, 1'b0, 32'h0, 4'h0, 32'h12345678, 1'b0);
        chk("alias_model", model_read(32'h0), 32'h12345678);
`endif

        // randomized mix against the byte-level model
        for (int n = 0; n < 300; n++) begin
            a  = {20'd0, 10'($urandom_range(0, DEPTH-1)), 2'($urandom_range(0, 3))};
            d  = $urandom;
            be = 4'($urandom_range(0, 15));
            op = $urandom_range(0, 2);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            if (op == 0) begin
                do_store(a, d, be);
            end else if (op == 1) begin
                do_load("rnd_ld", a, 1'b0, 32'h0, 4'h0, model_read(a), 1'b0);
            end else begin
                model_store(a, d, be);
                do_load("rnd_stld", a, 1'b1, d, be, model_read(a), 1'b0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
